// File: rtl/gray_frame_arbiter_if.sv
// rtl/gray_frame_arbiter_if.sv - pixel source, datapath and status bundle for gray_frame_arbiter
interface gray_frame_arbiter_if;
  logic [23:0] s0_data_in;
  logic        s0_valid_in;
  logic        s0_sof_in;
  logic        s0_busy_out;
  logic [23:0] s1_data_in;
  logic        s1_valid_in;
  logic        s1_sof_in;
  logic        s1_busy_out;
  logic [23:0] m_data_out;
  logic        m_valid_out;
  logic        m_sof_out;
  logic        m_busy_in;
  logic        o_sel;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [15:0] o_drop_cnt;

  modport slave (
    input  s0_data_in, s0_valid_in, s0_sof_in,
    output s0_busy_out,
    input  s1_data_in, s1_valid_in, s1_sof_in,
    output s1_busy_out,
    output m_data_out, m_valid_out, m_sof_out,
    input  m_busy_in,
    output o_sel, o_frame_done, o_frame_err, o_drop_cnt
  );

  modport master (
    output s0_data_in, s0_valid_in, s0_sof_in,
    input  s0_busy_out,
    output s1_data_in, s1_valid_in, s1_sof_in,
    input  s1_busy_out,
    input  m_data_out, m_valid_out, m_sof_out,
    output m_busy_in,
    input  o_sel, o_frame_done, o_frame_err, o_drop_cnt
  );
endinterface

// File: rtl/gray_frame_arbiter.sv
// rtl/gray_frame_arbiter.sv - frame-granular round-robin arbiter for two RGB pixel sources
module gray_frame_arbiter #(
  parameter int FRAME_PIXELS   = 307200,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(FRAME_PIXELS)
) (
  input logic                i_clk,
  input logic                i_rst,
  gray_frame_arbiter_if.slave bus
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic             sel;
  logic             last_sel;
  logic [CNT_W-1:0] pix_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [15:0]      drop_cnt;
  logic             frame_done;
  logic             frame_err;

  logic             req0, req1, drop0, drop1, grant_sel;
  logic             sel_valid, sel_sof;
  logic [23:0]      sel_data;
  logic             mid_sof, xfer, last_pix, timeout_hit;
  logic             m_valid, m_sof, busy0, busy1;
  logic [TO_W-1:0]  to_nxt;
  logic [16:0]      drop_sum;

  always_comb begin
    sel_valid = sel ? bus.s1_valid_in : bus.s0_valid_in;
    sel_sof   = sel ? bus.s1_sof_in   : bus.s0_sof_in;
    sel_data  = sel ? bus.s1_data_in  : bus.s0_data_in;
    req0      = bus.s0_valid_in & bus.s0_sof_in;
    req1      = bus.s1_valid_in & bus.s1_sof_in;
    drop0     = bus.s0_valid_in & ~bus.s0_sof_in;
    drop1     = bus.s1_valid_in & ~bus.s1_sof_in;
    // On simultaneous requests the source that did not own the last frame wins.
    grant_sel = (req0 && req1) ? ~last_sel : req1;
    mid_sof   = (state == ACTIVE) && (pix_cnt != '0) && sel_valid && sel_sof;
    m_valid   = ~i_rst && (state == ACTIVE) && sel_valid && ~mid_sof;
    m_sof     = ~i_rst && (state == ACTIVE) && (pix_cnt == '0) && sel_sof;
    xfer      = m_valid && ~bus.m_busy_in;
    last_pix  = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    to_nxt    = to_cnt + TO_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ACTIVE) && (pix_cnt != '0) &&
                  ~sel_valid && ~bus.m_busy_in && (to_nxt == TO_W'(TIMEOUT_CYCLES));
    drop_sum  = {1'b0, drop_cnt} + 17'(drop0) + 17'(drop1);
    busy0     = 1'b1;
    busy1     = 1'b1;
    if (!i_rst) begin
      if (state == IDLE) begin
        busy0 = req0;
        busy1 = req1;
      end else if (sel) begin
        busy1 = bus.m_busy_in | mid_sof;
      end else begin
        busy0 = bus.m_busy_in | mid_sof;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_sel   <= 1'b1;
      pix_cnt    <= '0;
      to_cnt     <= '0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (drop0 || drop1)
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
          if (req0 || req1) begin
            state   <= ACTIVE;
            sel     <= grant_sel;
            pix_cnt <= '0;
            to_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (mid_sof || timeout_hit) begin
            state     <= IDLE;
            last_sel  <= sel;
            frame_err <= 1'b1;
          end else if (xfer && last_pix) begin
            state      <= IDLE;
            last_sel   <= sel;
            frame_done <= 1'b1;
          end else begin
            if (xfer)
              pix_cnt <= pix_cnt + CNT_W'(1);
            // Only source-side gaps count toward the timeout, not datapath stalls.
            if (sel_valid)
              to_cnt <= '0;
            else if ((pix_cnt != '0) && !bus.m_busy_in)
              to_cnt <= to_nxt;
          end
        end
      endcase
    end
  end

  assign bus.s0_busy_out  = busy0;
  assign bus.s1_busy_out  = busy1;
  assign bus.m_data_out   = sel_data;
  assign bus.m_valid_out  = m_valid;
  assign bus.m_sof_out    = m_sof;
  assign bus.o_sel        = sel;
  assign bus.o_frame_done = frame_done;
  assign bus.o_frame_err  = frame_err;
  assign bus.o_drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_gray_frame_arbiter.sv
// tb/tb_gray_frame_arbiter.sv - directed self-checking bench for gray_frame_arbiter
module tb_gray_frame_arbiter;
  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  gray_frame_arbiter_if bus();

  gray_frame_arbiter #(
    .FRAME_PIXELS  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [23:0] sf_pix [4] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000};
  logic        ct_order [3] = '{1'b0, 1'b1, 1'b0};

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.s0_data_in  = '0;
    bus.s0_valid_in = 1'b0;
    bus.s0_sof_in   = 1'b0;
    bus.s1_data_in  = '0;
    bus.s1_valid_in = 1'b0;
    bus.s1_sof_in   = 1'b0;
    bus.m_busy_in   = 1'b0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = 24'h123456;
    bus.s1_valid_in = 1'b1; bus.s1_sof_in = 1'b0;
    tick();
    tick();
    checks++; if (bus.s0_busy_out !== 1'b1) begin errors++; $display("FAIL rst_s0_busy: got %b expected 1", bus.s0_busy_out); end
    checks++; if (bus.s1_busy_out !== 1'b1) begin errors++; $display("FAIL rst_s1_busy: got %b expected 1", bus.s1_busy_out); end
    checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", bus.m_valid_out); end
    checks++; if (bus.m_sof_out !== 1'b0) begin errors++; $display("FAIL rst_m_sof: got %b expected 0", bus.m_sof_out); end
    checks++; if (bus.o_sel !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b expected 0", bus.o_sel); end
    checks++; if (bus.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", bus.o_drop_cnt); end
    checks++; if (bus.o_frame_done !== 1'b0 || bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got done=%b err=%b expected 0 0", bus.o_frame_done, bus.o_frame_err); end
    clear_inputs();
    i_rst = 1'b0;
    tick();
    checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b expected 0", bus.m_valid_out); end
  endtask

  task automatic test_single_frame;
    apply_reset();
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = sf_pix[0];
    #1;
    checks++; if (bus.s0_busy_out !== 1'b1) begin errors++; $display("FAIL sf_req_busy: got %b expected 1", bus.s0_busy_out); end
    checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL sf_idle_valid: got %b expected 0", bus.m_valid_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.s0_data_in = sf_pix[i];
      bus.s0_sof_in  = (i == 0);
      #1;
      checks++; if (bus.m_valid_out !== 1'b1) begin errors++; $display("FAIL sf_valid[%0d]: got %b expected 1", i, bus.m_valid_out); end
      checks++; if (bus.m_data_out !== sf_pix[i]) begin errors++; $display("FAIL sf_data[%0d]: got %h expected %h", i, bus.m_data_out, sf_pix[i]); end
      checks++; if (bus.m_sof_out !== (i == 0)) begin errors++; $display("FAIL sf_sof[%0d]: got %b expected %b", i, bus.m_sof_out, (i == 0)); end
      checks++; if (bus.s0_busy_out !== 1'b0) begin errors++; $display("FAIL sf_busy[%0d]: got %b expected 0", i, bus.s0_busy_out); end
      checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL sf_early_done[%0d]: got %b expected 0", i, bus.o_frame_done); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (bus.o_frame_done !== 1'b1) begin errors++; $display("FAIL sf_done: got %b expected 1", bus.o_frame_done); end
    checks++; if (bus.o_sel !== 1'b0) begin errors++; $display("FAIL sf_sel: got %b expected 0", bus.o_sel); end
    tick();
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL sf_done_once: got %b expected 0", bus.o_frame_done); end
  endtask

  task automatic test_contention;
    int idx0, idx1, fcount, dcount;
    logic b0, b1, cur;
    logic [23:0] exp_d;
    apply_reset();
    idx0 = 0; idx1 = 0; fcount = 0; dcount = 0;
    for (int c = 0; c < 40 && dcount < 3; c++) begin
      bus.s0_valid_in = 1'b1; bus.s0_sof_in = (idx0 == 0); bus.s0_data_in = 24'h100000 + 24'(idx0);
      bus.s1_valid_in = 1'b1; bus.s1_sof_in = (idx1 == 0); bus.s1_data_in = 24'h200000 + 24'(idx1);
      #1;
      if (bus.m_valid_out && bus.m_sof_out) begin
        if (fcount < 3) begin
          checks++; if (bus.o_sel !== ct_order[fcount]) begin errors++; $display("FAIL ct_order[%0d]: got %b expected %b", fcount, bus.o_sel, ct_order[fcount]); end
        end
        fcount++;
      end
      if (bus.m_valid_out && fcount > 0 && fcount <= 3) begin
        cur = ct_order[fcount-1];
        exp_d = cur ? 24'h200000 + 24'(idx1) : 24'h100000 + 24'(idx0);
        checks++; if (bus.m_data_out !== exp_d) begin errors++; $display("FAIL ct_data: got %h expected %h", bus.m_data_out, exp_d); end
        checks++; if ((cur ? bus.s0_busy_out : bus.s1_busy_out) !== 1'b1) begin errors++; $display("FAIL ct_other_busy: got 0 expected 1 (frame %0d)", fcount); end
      end
      if (bus.o_frame_done) dcount++;
      b0 = bus.s0_busy_out;
      b1 = bus.s1_busy_out;
      tick();
      if (!b0) idx0 = (idx0 + 1) % 4;
      if (!b1) idx1 = (idx1 + 1) % 4;
    end
    checks++; if (dcount != 3) begin errors++; $display("FAIL ct_done_count: got %0d expected 3", dcount); end
    checks++; if (fcount != 3) begin errors++; $display("FAIL ct_frame_count: got %0d expected 3", fcount); end
    checks++; if (bus.o_drop_cnt !== 16'd0) begin errors++; $display("FAIL ct_drop: got %0d expected 0", bus.o_drop_cnt); end
  endtask

  task automatic test_backpressure;
    logic        busy_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int          pidx_tab [8] = '{0, 0, 1, 2, 2, 2, 2, 3};
    logic [23:0] got [4];
    int          n;
    apply_reset();
    n = 0;
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = sf_pix[0];
    tick();
    for (int c = 1; c < 8; c++) begin
      bus.s0_data_in = sf_pix[pidx_tab[c]];
      bus.s0_sof_in  = (pidx_tab[c] == 0);
      bus.m_busy_in  = busy_tab[c];
      #1;
      checks++; if (bus.s0_busy_out !== busy_tab[c]) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected %b", c, bus.s0_busy_out, busy_tab[c]); end
      checks++; if (bus.m_data_out !== sf_pix[pidx_tab[c]]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", c, bus.m_data_out, sf_pix[pidx_tab[c]]); end
      checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL bp_early_done[%0d]: got %b expected 0", c, bus.o_frame_done); end
      if (bus.m_valid_out && !bus.m_busy_in) begin
        if (n < 4) got[n] = bus.m_data_out;
        n++;
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (bus.o_frame_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", bus.o_frame_done); end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_xfer_count: got %0d expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++; if (got[i] !== sf_pix[i]) begin errors++; $display("FAIL bp_seq[%0d]: got %h expected %h", i, got[i], sf_pix[i]); end
    end
  endtask

  task automatic test_stray;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.s1_valid_in = 1'b1; bus.s1_sof_in = 1'b0; bus.s1_data_in = 24'hABC000 + 24'(i);
      #1;
      checks++; if (bus.s1_busy_out !== 1'b0) begin errors++; $display("FAIL st_busy[%0d]: got %b expected 0", i, bus.s1_busy_out); end
      checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL st_valid[%0d]: got %b expected 0", i, bus.m_valid_out); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (bus.o_drop_cnt !== 16'd3) begin errors++; $display("FAIL st_drop3: got %0d expected 3", bus.o_drop_cnt); end
    bus.s0_valid_in = 1'b1; bus.s1_valid_in = 1'b1;
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.o_drop_cnt !== 16'd5) begin errors++; $display("FAIL st_drop_both: got %0d expected 5", bus.o_drop_cnt); end
  endtask

  task automatic test_truncation;
    apply_reset();
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = 24'h00FF00;
    tick();
    #1;
    checks++; if (bus.m_valid_out !== 1'b1 || bus.m_sof_out !== 1'b1) begin errors++; $display("FAIL tr_first: got valid=%b sof=%b expected 1 1", bus.m_valid_out, bus.m_sof_out); end
    tick();
    bus.s0_sof_in = 1'b0; bus.s0_data_in = 24'h112233;
    #1;
    checks++; if (bus.m_valid_out !== 1'b1 || bus.m_sof_out !== 1'b0) begin errors++; $display("FAIL tr_second: got valid=%b sof=%b expected 1 0", bus.m_valid_out, bus.m_sof_out); end
    tick();
    bus.s0_sof_in = 1'b1; bus.s0_data_in = 24'h0000FF;
    #1;
    checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL tr_blocked_valid: got %b expected 0", bus.m_valid_out); end
    checks++; if (bus.s0_busy_out !== 1'b1) begin errors++; $display("FAIL tr_blocked_busy: got %b expected 1", bus.s0_busy_out); end
    tick();
    checks++; if (bus.o_frame_err !== 1'b1) begin errors++; $display("FAIL tr_err: got %b expected 1", bus.o_frame_err); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL tr_no_done: got %b expected 0", bus.o_frame_done); end
    checks++; if (bus.m_valid_out !== 1'b0 || bus.s0_busy_out !== 1'b1) begin errors++; $display("FAIL tr_idle_hold: got valid=%b busy=%b expected 0 1", bus.m_valid_out, bus.s0_busy_out); end
    tick();
    checks++; if (bus.m_valid_out !== 1'b1 || bus.m_sof_out !== 1'b1) begin errors++; $display("FAIL tr_regrant: got valid=%b sof=%b expected 1 1", bus.m_valid_out, bus.m_sof_out); end
    checks++; if (bus.m_data_out !== 24'h0000FF) begin errors++; $display("FAIL tr_regrant_data: got %h expected 0000ff", bus.m_data_out); end
    checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL tr_err_once: got %b expected 0", bus.o_frame_err); end
  endtask

  task automatic test_timeout;
    apply_reset();
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = 24'h010101;
    tick();
    tick();
    bus.s0_sof_in = 1'b0; bus.s0_data_in = 24'h020202;
    tick();
    clear_inputs();
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b expected 0", k, bus.o_frame_err); end
      tick();
    end
    checks++; if (bus.o_frame_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", bus.o_frame_err); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL to_no_done: got %b expected 0", bus.o_frame_done); end
    bus.s1_valid_in = 1'b1; bus.s1_sof_in = 1'b0;
    #1;
    checks++; if (bus.s1_busy_out !== 1'b0) begin errors++; $display("FAIL to_idle_busy: got %b expected 0", bus.s1_busy_out); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL to_err_once: got %b expected 0", bus.o_frame_err); end
    checks++; if (bus.o_drop_cnt !== 16'd1) begin errors++; $display("FAIL to_drop: got %0d expected 1", bus.o_drop_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    apply_reset();
    bus.s0_valid_in = 1'b1; bus.s0_sof_in = 1'b1; bus.s0_data_in = 24'h0A0A0A;
    tick();
    tick();
    bus.s0_sof_in = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    checks++; if (bus.m_valid_out !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", bus.m_valid_out); end
    checks++; if (bus.s0_busy_out !== 1'b1 || bus.s1_busy_out !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b %b expected 1 1", bus.s0_busy_out, bus.s1_busy_out); end
    tick();
    i_rst = 1'b0;
    clear_inputs();
    bus.s1_valid_in = 1'b1; bus.s1_sof_in = 1'b0;
    #1;
    checks++; if (bus.s1_busy_out !== 1'b0) begin errors++; $display("FAIL rm_idle: got %b expected 0", bus.s1_busy_out); end
    checks++; if (bus.o_frame_done !== 1'b0 || bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL rm_pulses: got done=%b err=%b expected 0 0", bus.o_frame_done, bus.o_frame_err); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.o_frame_done !== 1'b0 || bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL rm_pulses_late: got done=%b err=%b expected 0 0", bus.o_frame_done, bus.o_frame_err); end
    checks++; if (bus.o_drop_cnt !== 16'd1) begin errors++; $display("FAIL rm_drop: got %0d expected 1", bus.o_drop_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_clk  = 1'b0;
    i_rst  = 1'b1;
    clear_inputs();
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_stray();
    test_truncation();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
